// File: rtl/dispatch_queue_pkg.sv
// Shared robIdx type and age helpers; used by the dispatch queue, ROB and reservation stations.
package dispatch_queue_pkg;
  localparam int ROB_W_MAX = 16;

  localparam logic LEVEL_FLUSH_AFTER  = 1'b0;
  localparam logic LEVEL_FLUSH_ITSELF = 1'b1;

  typedef struct packed {
    logic                 flag;
    logic [ROB_W_MAX-1:0] value;
  } robIdx_t;

  // The flag toggles on every ROB wrap, so a differing flag inverts the value compare.
  function automatic logic isAfter(robIdx_t a, robIdx_t b);
    return (a.flag ^ b.flag) ^ (a.value > b.value);
  endfunction

  function automatic logic isEqual(robIdx_t a, robIdx_t b);
    return (a.flag == b.flag) && (a.value == b.value);
  endfunction
endpackage

// File: rtl/dispatch_queue_flush_mask.sv
// Per-entry redirect kill vector and survivor count for the dispatch queue.
module dispatch_queue_flush_mask
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic [PTR_W-1:0]            head,
  input  logic [CNT_W-1:0]            count,
  input  logic [DEPTH-1:0]            entFlag,
  input  logic [DEPTH-1:0][ROB_W-1:0] entValue,
  input  logic                        rdFlag,
  input  logic [ROB_W-1:0]            rdValue,
  input  logic                        rdLevel,
  output logic [DEPTH-1:0]            killMask,
  output logic [CNT_W-1:0]            survivors
);
  robIdx_t          rdIdx;
  logic [DEPTH-1:0] occupied;

  assign rdIdx = '{flag: rdFlag, value: ROB_W_MAX'(rdValue)};

  for (genvar i = 0; i < DEPTH; i++) begin : gEnt
    logic [PTR_W-1:0] offset;
    robIdx_t          entIdx;
    assign offset      = PTR_W'(i) - head;
    assign occupied[i] = {1'b0, offset} < count;
    assign entIdx      = '{flag: entFlag[i], value: ROB_W_MAX'(entValue[i])};
    assign killMask[i] = occupied[i] &
                         (isAfter(entIdx, rdIdx) |
                          ((rdLevel == LEVEL_FLUSH_ITSELF) & isEqual(entIdx, rdIdx)));
  end

  always_comb begin
    survivors = '0;
    for (int i = 0; i < DEPTH; i++)
      survivors = survivors + CNT_W'(occupied[i] & ~killMask[i]);
  end
endmodule

// File: rtl/dispatch_queue.sv
// In-order uop buffer feeding the dispatch arbiter; redirects roll the tail back to the last survivor.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int UOP_W = 64,
  parameter int ROB_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [UOP_W-1:0] io_enq_bits_uop,
  input  logic             io_enq_bits_robIdx_flag,
  input  logic [ROB_W-1:0] io_enq_bits_robIdx_value,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [UOP_W-1:0] io_deq_bits_uop,
  output logic             io_deq_bits_robIdx_flag,
  output logic [ROB_W-1:0] io_deq_bits_robIdx_value,
  input  logic             io_redirect_valid,
  input  logic             io_redirect_bits_robIdx_flag,
  input  logic [ROB_W-1:0] io_redirect_bits_robIdx_value,
  input  logic             io_redirect_bits_level,
  output logic [CNT_W-1:0] io_count
);
  logic [DEPTH-1:0][UOP_W-1:0] uopMem;
  logic [DEPTH-1:0]            flagMem;
  logic [DEPTH-1:0][ROB_W-1:0] valueMem;
  logic [PTR_W-1:0]            head, tail;
  logic [CNT_W-1:0]            count, survivors;
  logic [DEPTH-1:0]            killMask;
  logic                        enqFire, deqFire;

  // Full check uses registered count only: a same-cycle deq never frees a slot for enq.
  assign io_enq_ready = (count < CNT_W'(DEPTH)) & ~io_redirect_valid;
  assign io_deq_valid = (count != '0) & ~io_redirect_valid;
  assign enqFire      = io_enq_valid & io_enq_ready;
  assign deqFire      = io_deq_valid & io_deq_ready;

  assign io_deq_bits_uop          = uopMem[head];
  assign io_deq_bits_robIdx_flag  = flagMem[head];
  assign io_deq_bits_robIdx_value = valueMem[head];
  assign io_count                 = count;

  dispatch_queue_flush_mask #(.DEPTH(DEPTH), .ROB_W(ROB_W)) uFlushMask (
    .head     (head),
    .count    (count),
    .entFlag  (flagMem),
    .entValue (valueMem),
    .rdFlag   (io_redirect_bits_robIdx_flag),
    .rdValue  (io_redirect_bits_robIdx_value),
    .rdLevel  (io_redirect_bits_level),
    .killMask (killMask),
    .survivors(survivors)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (io_redirect_valid) begin
      // Killed entries are a suffix, so survivors sit contiguously from head.
      tail  <= head + survivors[PTR_W-1:0];
      count <= survivors;
    end else begin
      if (enqFire) tail <= tail + 1'b1;
      if (deqFire) head <= head + 1'b1;
      count <= count + CNT_W'(enqFire) - CNT_W'(deqFire);
    end
  end

  always_ff @(posedge clock) begin
    if (enqFire) begin
      uopMem[tail]   <= io_enq_bits_uop;
      flagMem[tail]  <= io_enq_bits_robIdx_flag;
      valueMem[tail] <= io_enq_bits_robIdx_value;
    end
  end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order uop buffer between rename/dispatch and the execution-block dispatch arbiter that routes uops to reservation stations by fuType. It absorbs one uop per cycle, presents the oldest uop on a ready/valid output, and, on a redirect, cancels every buffered uop younger than the redirecting robIdx by rolling back its tail.

## Interface
Parameters:
- DEPTH, 8: entries; power of two, ≥2.
- UOP_W, 64: width of the opaque uop payload (cf/ctrl/psrc/pdest/lq/sq fields, packed by the parent).
- ROB_W, 5: width of robIdx value.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_enq_valid  in  1  upstream uop valid.
- io_enq_ready  out  1  queue accepts this cycle.
- io_enq_bits_uop  in  UOP_W  payload.
- io_enq_bits_robIdx_flag  in  1  ROB wrap flag.
- io_enq_bits_robIdx_value  in  ROB_W  ROB index.
- io_deq_valid  out  1  head uop valid, to dispatch arbiter io_in_valid.
- io_deq_ready  in  1  from dispatch arbiter io_in_ready.
- io_deq_bits_uop  out  UOP_W  head payload.
- io_deq_bits_robIdx_flag / _value  out  1 / ROB_W  head robIdx.
- io_redirect_valid  in  1  flush request.
- io_redirect_bits_robIdx_flag / _value  in  1 / ROB_W  redirecting uop.
- io_redirect_bits_level  in  1  0 = flush after, 1 = flush itself too.
- io_count  out  clog2(DEPTH)+1  registered occupancy.

## Operation
- Circular storage, head/tail pointers of clog2(DEPTH) bits plus registered count; enq at tail, deq at head.
- Enq fires on io_enq_valid & io_enq_ready; io_enq_ready = (count < DEPTH) & !io_redirect_valid. No full-queue bypass: a deq in the same cycle does not free a slot for that cycle's enq.
- Deq fires on io_deq_valid & io_deq_ready; io_deq_valid = (count != 0) & !io_redirect_valid. Output bits are head entry contents (combinational read of registered storage).
- Age compare: isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value). Entry killed if isAfter(entry, redirect), or (level=1 and entry robIdx == redirect robIdx).
- Entries are in program order, so killed entries form a suffix. On redirect: survivors = number of occupied, unkilled entries; next tail = head + survivors (mod DEPTH); next count = survivors. No enq/deq in that cycle.
- Simultaneous enq+deq when not full and not empty: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count saturates nowhere (handshake rules keep it in 0..DEPTH).
- Payload storage needs no reset; only pointers and count reset.

## Timing
- Reset: head=0, tail=0, count=0 → io_deq_valid=0, io_enq_ready=1 (if no redirect), io_count=0, deq bits don't-care.
- Enq-to-deq latency: 1 cycle (uop accepted in cycle N visible at io_deq in N+1 if queue was empty).
- Redirect in cycle N: io_deq_valid and io_enq_ready low in N; pruned state visible from N+1.
- Reset asserted mid-operation overrides redirect, enq, deq: state cleared next edge.
- io_count reflects registered state (post previous edge).

## Structure
- Shared package: robIdx struct (flag, value), isAfter/isEqual functions, redirect level encodings; same helpers serve ROB and reservation stations.
- One sub-module natural: dispatch_queue_flush_mask — combinational per-entry kill vector plus popcount of survivors; the top keeps storage, pointers, handshakes.

## Test plan
- Reset then enq robIdx 0..7 (flag 0) back-to-back, io_deq_ready=0 → io_count=8, io_enq_ready=0 after 8th; release ready → dequeued in order 0..7, 1 uop/cycle.
- Empty queue, enq robIdx 3 in cycle N → io_deq_valid=1 with robIdx 3 in N+1, not in N.
- Full queue, enq_valid and deq_ready both high → deq fires, enq refused that cycle, count goes 8→7.
- Queue holds robIdx 10..15, redirect robIdx 12 level=0 → next cycle count=3, deq order 10,11,12; level=1 → count=2.
- Wrap case: queue holds (flag0,30),(flag0,31),(flag1,0),(flag1,1); redirect (flag0,31) level=0 → 2 survivors, (flag1,*) removed; pointers wrap past DEPTH during refill of 8 more uops without loss.
- Redirect with enq_valid and deq_ready high → no enq, no deq that cycle; reset asserted with redirect → count=0 next cycle.
